// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// ALU operation codes, datapath select values, FSM states and decode payloads.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALU_W   = 5;
  localparam int unsigned SEL_W   = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_LBU   = 6'b100100;
  localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [FUNCT_W-1:0] F_SLL  = 6'b000000;
  localparam logic [FUNCT_W-1:0] F_SRL  = 6'b000010;
  localparam logic [FUNCT_W-1:0] F_SRA  = 6'b000011;
  localparam logic [FUNCT_W-1:0] F_JR   = 6'b001000;
  localparam logic [FUNCT_W-1:0] F_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_ADDU = 6'b100001;
  localparam logic [FUNCT_W-1:0] F_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] F_SUBU = 6'b100011;
  localparam logic [FUNCT_W-1:0] F_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] F_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] F_SLT  = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [ALU_W-1:0] ALU_OR  = 5'b00001;
  localparam logic [ALU_W-1:0] ALU_AND = 5'b00010;
  localparam logic [ALU_W-1:0] ALU_SLL = 5'b00100;
  localparam logic [ALU_W-1:0] ALU_SRL = 5'b00101;
  localparam logic [ALU_W-1:0] ALU_SRA = 5'b00110;
  localparam logic [ALU_W-1:0] ALU_LUI = 5'b00111;
  localparam logic [ALU_W-1:0] ALU_ORI = 5'b01000;
  localparam logic [ALU_W-1:0] ALU_SUB = 5'b01001;
  localparam logic [ALU_W-1:0] ALU_SLT = 5'b01010;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [SEL_W-1:0] PCSRC_REGA   = 2'b11;

  localparam logic [SEL_W-1:0] REGDST_RT = 2'b00;
  localparam logic [SEL_W-1:0] REGDST_RD = 2'b01;
  localparam logic [SEL_W-1:0] REGDST_RA = 2'b10;

  localparam logic [SEL_W-1:0] M2R_ALU = 2'b00;
  localparam logic [SEL_W-1:0] M2R_MDR = 2'b01;
  localparam logic [SEL_W-1:0] M2R_PC  = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_REG   = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_SHAMT = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_REG     = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [SEL_W-1:0] MODE_WORD  = 2'b00;
  localparam logic [SEL_W-1:0] MODE_SBYTE = 2'b01;
  localparam logic [SEL_W-1:0] MODE_UBYTE = 2'b10;

  typedef enum logic [5:0] {
    S_RESET     = 6'd0,
    S_FETCH     = 6'd1,
    S_DECODE    = 6'd2,
    S_MEM_ADDR  = 6'd3,
    S_MEM_READ  = 6'd4,
    S_MEM_WB    = 6'd5,
    S_MEM_WRITE = 6'd6,
    S_RTYPE_EX  = 6'd7,
    S_RTYPE_WB  = 6'd8,
    S_IMM_EX    = 6'd9,
    S_IMM_WB    = 6'd10,
    S_BRANCH    = 6'd11,
    S_JUMP      = 6'd12,
    S_JAL       = 6'd13,
    S_JR        = 6'd14,
    S_HALT      = 6'd15
  } state_e;

  typedef enum logic [2:0] {
    IC_LOAD    = 3'd0,
    IC_STORE   = 3'd1,
    IC_RTYPE   = 3'd2,
    IC_IMM     = 3'd3,
    IC_BRANCH  = 3'd4,
    IC_JUMP    = 3'd5,
    IC_JAL     = 3'd6,
    IC_ILLEGAL = 3'd7
  } iclass_e;

  // Instruction-register decode, consumed by the FSM
  typedef struct packed {
    iclass_e          iclass;
    logic             is_bne;
    logic [SEL_W-1:0] mem_mode;
    logic [ALU_W-1:0] alu_imm;
    logic [ALU_W-1:0] alu_rtype;
    logic             r_shift;
    logic             r_jr;
    logic             r_legal;
  } dec_t;

  // One cycle's worth of datapath control
  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic [SEL_W-1:0] mem_mode;
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch_ne;
    logic [SEL_W-1:0] pc_source;
    logic             iord;
    logic             ir_write;
    logic             reg_write;
    logic [SEL_W-1:0] reg_dst;
    logic [SEL_W-1:0] mem_to_reg;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [ALU_W-1:0] alu_op;
    logic             halted;
    logic             illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_controller_v2_if.sv
// Instruction-register inputs, memory handshake and datapath control outputs
// of the multicycle controller.
interface mips_mc_controller_v2_if #(
  parameter int unsigned ALUOP_W = 5
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               mem_ready;
  logic               MemRead;
  logic               MemWrite;
  logic [1:0]         MemMode;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               BranchNe;
  logic [1:0]         PCSource;
  logic               IorD;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         RegDst;
  logic [1:0]         MemToReg;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOP;
  logic               halted;
  logic               illegal;

  modport master (
    output op, funct, mem_ready,
    input  MemRead, MemWrite, MemMode, PCWrite, PCWriteCond, BranchNe, PCSource,
           IorD, IRWrite, RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOP,
           halted, illegal
  );

  modport slave (
    input  op, funct, mem_ready,
    output MemRead, MemWrite, MemMode, PCWrite, PCWriteCond, BranchNe, PCSource,
           IorD, IRWrite, RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB, ALUOP,
           halted, illegal
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational op/funct decode: instruction class, ALU codes, access size
// and legality of the R-type function field.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output dec_t               dec_o
);

  always_comb begin
    dec_o        = '0;
    dec_o.iclass = IC_ILLEGAL;

    case (op_i)
      OP_LW:    begin dec_o.iclass = IC_LOAD;  dec_o.mem_mode = MODE_WORD;  end
      OP_LB:    begin dec_o.iclass = IC_LOAD;  dec_o.mem_mode = MODE_SBYTE; end
      OP_LBU:   begin dec_o.iclass = IC_LOAD;  dec_o.mem_mode = MODE_UBYTE; end
      OP_SW:    begin dec_o.iclass = IC_STORE; dec_o.mem_mode = MODE_WORD;  end
      OP_SB:    begin dec_o.iclass = IC_STORE; dec_o.mem_mode = MODE_SBYTE; end
      OP_RTYPE: dec_o.iclass = IC_RTYPE;
      OP_ORI:   begin dec_o.iclass = IC_IMM; dec_o.alu_imm = ALU_ORI; end
      OP_LUI:   begin dec_o.iclass = IC_IMM; dec_o.alu_imm = ALU_LUI; end
      OP_ADDI,
      OP_ADDIU: begin dec_o.iclass = IC_IMM; dec_o.alu_imm = ALU_ADD; end
      OP_SLTI:  begin dec_o.iclass = IC_IMM; dec_o.alu_imm = ALU_SLT; end
      OP_BEQ:   dec_o.iclass = IC_BRANCH;
      OP_BNE:   begin dec_o.iclass = IC_BRANCH; dec_o.is_bne = 1'b1; end
      OP_J:     dec_o.iclass = IC_JUMP;
      OP_JAL:   dec_o.iclass = IC_JAL;
      default:  dec_o.iclass = IC_ILLEGAL;
    endcase

    // Function field only matters once the FSM reaches RTYPE_EX
    case (funct_i)
      F_ADD, F_ADDU: begin dec_o.r_legal = 1'b1; dec_o.alu_rtype = ALU_ADD; end
      F_SUB, F_SUBU: begin dec_o.r_legal = 1'b1; dec_o.alu_rtype = ALU_SUB; end
      F_OR:          begin dec_o.r_legal = 1'b1; dec_o.alu_rtype = ALU_OR;  end
      F_AND:         begin dec_o.r_legal = 1'b1; dec_o.alu_rtype = ALU_AND; end
      F_SLT:         begin dec_o.r_legal = 1'b1; dec_o.alu_rtype = ALU_SLT; end
      F_SLL: begin dec_o.r_legal = 1'b1; dec_o.r_shift = 1'b1; dec_o.alu_rtype = ALU_SLL; end
      F_SRL: begin dec_o.r_legal = 1'b1; dec_o.r_shift = 1'b1; dec_o.alu_rtype = ALU_SRL; end
      F_SRA: begin dec_o.r_legal = 1'b1; dec_o.r_shift = 1'b1; dec_o.alu_rtype = ALU_SRA; end
      F_JR:          begin dec_o.r_legal = 1'b1; dec_o.r_jr = 1'b1; end
      default:       dec_o.r_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller_v2.sv
// Multicycle MIPS control FSM with memory wait states, illegal-instruction
// handling and combinational per-state datapath controls.
module mips_mc_controller_v2
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W         = 5,
  parameter bit          MEM_HANDSHAKE   = 1'b1,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mips_mc_controller_v2_if.slave bus
);

  localparam state_e ILLEGAL_NEXT = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

  state_e state_q, state_d;
  dec_t   dec;
  ctrl_t  ctrl;
  logic   mem_rdy;

  mips_ctrl_decode u_decode (
    .op_i    (bus.op),
    .funct_i (bus.funct),
    .dec_o   (dec)
  );

  assign mem_rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RESET;
    else          state_q <= state_d;
  end

  // Next state and per-state controls; everything not named stays 0
  always_comb begin
    state_d = state_q;
    ctrl    = '0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_source = PCSRC_ALU;
        if (mem_rdy) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end
      end

      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SL2;
        case (dec.iclass)
          IC_LOAD, IC_STORE: state_d = S_MEM_ADDR;
          IC_RTYPE:          state_d = S_RTYPE_EX;
          IC_IMM:            state_d = S_IMM_EX;
          IC_BRANCH:         state_d = S_BRANCH;
          IC_JUMP:           state_d = S_JUMP;
          IC_JAL:            state_d = S_JAL;
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = ILLEGAL_NEXT;
          end
        endcase
      end

      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        state_d        = (dec.iclass == IC_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.mem_mode = dec.mem_mode;
        if (mem_rdy) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MDR;
        ctrl.reg_dst    = REGDST_RT;
        state_d         = S_FETCH;
      end

      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_mode  = dec.mem_mode;
        if (mem_rdy) state_d = S_FETCH;
      end

      S_RTYPE_EX: begin
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_src_a = dec.r_shift ? SRCA_SHAMT : SRCA_REG;
        ctrl.alu_op    = dec.alu_rtype;
        if (!dec.r_legal) begin
          ctrl.illegal = 1'b1;
          state_d      = ILLEGAL_NEXT;
        end else if (dec.r_jr) begin
          state_d = S_JR;
        end else begin
          state_d = S_RTYPE_WB;
        end
      end

      S_RTYPE_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RD;
        ctrl.mem_to_reg = M2R_ALU;
        state_d         = S_FETCH;
      end

      S_IMM_EX: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = dec.alu_imm;
        state_d        = S_IMM_WB;
      end

      S_IMM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = REGDST_RT;
        state_d        = S_FETCH;
      end

      S_BRANCH: begin
        ctrl.alu_src_a     = SRCA_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
        ctrl.branch_ne     = dec.is_bne;
        state_d            = S_FETCH;
      end

      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        state_d        = S_FETCH;
      end

      // Link value is the already-incremented PC, written on the same edge the PC loads
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REGDST_RA;
        ctrl.mem_to_reg = M2R_PC;
        state_d         = S_FETCH;
      end

      S_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_REGA;
        state_d        = S_FETCH;
      end

      S_HALT: ctrl.halted = 1'b1;

      default: state_d = S_RESET;
    endcase
  end

  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.MemMode     = ctrl.mem_mode;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.BranchNe    = ctrl.branch_ne;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.IorD        = ctrl.iord;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.MemToReg    = ctrl.mem_to_reg;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOP       = ALUOP_W'(ctrl.alu_op);
  assign bus.halted      = ctrl.halted;
  assign bus.illegal     = ctrl.illegal;

endmodule

// File: tb/tb_mips_mc_controller_v2.sv
// Directed per-cycle vectors for the multicycle controller: one instance with
// handshake and halt-on-illegal, one without either and a wider ALUOP.
module tb_mips_mc_controller_v2;

  localparam logic [5:0] T_RT   = 6'b000000;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_JAL  = 6'b000011;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_SLTI = 6'b001010;
  localparam logic [5:0] T_LUI  = 6'b001111;
  localparam logic [5:0] T_LB   = 6'b100000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_LBU  = 6'b100100;
  localparam logic [5:0] T_SB   = 6'b101000;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BAD  = 6'b111111;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_BAD  = 6'b000001;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_mode;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [7:0] alu_op;
    logic       halted;
    logic       illegal;
  } outs_t;

  typedef struct {
    bit         sel;
    logic [5:0] op;
    logic [5:0] funct;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  logic clk, rst_h, rst_n2;
  int   n_tests, n_fail;
  vec_t vecs[$];

  outs_t e_zero, e_fw, e_fr, e_dec, e_dec_ill, e_maddr, e_mrd_w, e_mrd_b, e_mrd_u,
         e_mwb, e_mwr_w, e_mwr_b, e_bne, e_jal, e_jmp, e_jr, e_ex_a, e_rill,
         e_sra, e_slt, e_rwb, e_slti, e_lui, e_iwb, e_halt;

  mips_mc_controller_v2_if #(.ALUOP_W(5)) bus_h ();
  mips_mc_controller_v2_if #(.ALUOP_W(8)) bus_n ();

  mips_mc_controller_v2 #(.ALUOP_W(5)) dut_h (
    .clk     (clk),
    .reset_n (rst_h),
    .bus     (bus_h)
  );

  mips_mc_controller_v2 #(.ALUOP_W(8), .MEM_HANDSHAKE(1'b0), .HALT_ON_ILLEGAL(1'b0)) dut_n (
    .clk     (clk),
    .reset_n (rst_n2),
    .bus     (bus_n)
  );

  outs_t act_h, act_n;
  assign act_h = {bus_h.MemRead, bus_h.MemWrite, bus_h.MemMode, bus_h.PCWrite,
                  bus_h.PCWriteCond, bus_h.BranchNe, bus_h.PCSource, bus_h.IorD,
                  bus_h.IRWrite, bus_h.RegWrite, bus_h.RegDst, bus_h.MemToReg,
                  bus_h.ALUSrcA, bus_h.ALUSrcB, 8'(bus_h.ALUOP), bus_h.halted,
                  bus_h.illegal};
  assign act_n = {bus_n.MemRead, bus_n.MemWrite, bus_n.MemMode, bus_n.PCWrite,
                  bus_n.PCWriteCond, bus_n.BranchNe, bus_n.PCSource, bus_n.IorD,
                  bus_n.IRWrite, bus_n.RegWrite, bus_n.RegDst, bus_n.MemToReg,
                  bus_n.ALUSrcA, bus_n.ALUSrcB, bus_n.ALUOP, bus_n.halted,
                  bus_n.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input bit sel, input outs_t exp, input string name);
    outs_t act;
    act = sel ? act_n : act_h;
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Drive inputs just after the falling edge, sample the controls 1ns later
  task automatic step(input bit sel, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input outs_t exp, input string name);
    @(negedge clk);
    if (!sel) begin
      bus_h.op = op; bus_h.funct = fn; bus_h.mem_ready = rdy;
    end else begin
      bus_n.op = op; bus_n.funct = fn; bus_n.mem_ready = rdy;
    end
    #1 chk(sel, exp, name);
  endtask

  task automatic add(input bit sel, input logic [5:0] op, input logic [5:0] fn,
                     input logic rdy, input outs_t exp);
    vec_t v;
    v.sel = sel; v.op = op; v.funct = fn; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic run_vectors(input bit sel);
    for (int i = 0; i < vecs.size(); i++)
      if (vecs[i].sel == sel)
        step(sel, vecs[i].op, vecs[i].funct, vecs[i].rdy, vecs[i].exp,
             $sformatf("vec%0d", i));
  endtask

  task automatic init_exp();
    e_zero    = '0;
    e_fw      = '0; e_fw.mem_read = 1'b1; e_fw.alu_src_b = 2'b01;
    e_fr      = e_fw; e_fr.ir_write = 1'b1; e_fr.pc_write = 1'b1;
    e_dec     = '0; e_dec.alu_src_b = 2'b11;
    e_dec_ill = e_dec; e_dec_ill.illegal = 1'b1;
    e_maddr   = '0; e_maddr.alu_src_a = 2'b01; e_maddr.alu_src_b = 2'b10;
    e_mrd_w   = '0; e_mrd_w.mem_read = 1'b1; e_mrd_w.iord = 1'b1;
    e_mrd_b   = e_mrd_w; e_mrd_b.mem_mode = 2'b01;
    e_mrd_u   = e_mrd_w; e_mrd_u.mem_mode = 2'b10;
    e_mwb     = '0; e_mwb.reg_write = 1'b1; e_mwb.mem_to_reg = 2'b01;
    e_mwr_w   = '0; e_mwr_w.mem_write = 1'b1; e_mwr_w.iord = 1'b1;
    e_mwr_b   = e_mwr_w; e_mwr_b.mem_mode = 2'b01;
    e_bne     = '0; e_bne.alu_src_a = 2'b01; e_bne.alu_op = 8'b0000_1001;
    e_bne.pc_source = 2'b01; e_bne.pc_write_cond = 1'b1; e_bne.branch_ne = 1'b1;
    e_jmp     = '0; e_jmp.pc_write = 1'b1; e_jmp.pc_source = 2'b10;
    e_jal     = e_jmp; e_jal.reg_write = 1'b1; e_jal.reg_dst = 2'b10; e_jal.mem_to_reg = 2'b10;
    e_jr      = '0; e_jr.pc_write = 1'b1; e_jr.pc_source = 2'b11;
    e_ex_a    = '0; e_ex_a.alu_src_a = 2'b01;
    e_rill    = e_ex_a; e_rill.illegal = 1'b1;
    e_sra     = '0; e_sra.alu_src_a = 2'b10; e_sra.alu_op = 8'b0000_0110;
    e_slt     = e_ex_a; e_slt.alu_op = 8'b0000_1010;
    e_rwb     = '0; e_rwb.reg_write = 1'b1; e_rwb.reg_dst = 2'b01;
    e_slti    = e_maddr; e_slti.alu_op = 8'b0000_1010;
    e_lui     = e_maddr; e_lui.alu_op = 8'b0000_0111;
    e_iwb     = '0; e_iwb.reg_write = 1'b1;
    e_halt    = '0; e_halt.halted = 1'b1;
  endtask

  task automatic build_table();
    // LW: 2 FETCH waits + 3 MEM_READ waits -> 10 cycles
    add(0, T_LW, 6'd0, 1'b0, e_fw);   add(0, T_LW, 6'd0, 1'b0, e_fw);
    add(0, T_LW, 6'd0, 1'b1, e_fr);   add(0, T_LW, 6'd0, 1'b0, e_dec);
    add(0, T_LW, 6'd0, 1'b1, e_maddr);
    add(0, T_LW, 6'd0, 1'b0, e_mrd_w); add(0, T_LW, 6'd0, 1'b0, e_mrd_w);
    add(0, T_LW, 6'd0, 1'b0, e_mrd_w); add(0, T_LW, 6'd0, 1'b1, e_mrd_w);
    add(0, T_LW, 6'd0, 1'b0, e_mwb);
    add(0, T_BNE, 6'd0, 1'b1, e_fr);  add(0, T_BNE, 6'd0, 1'b1, e_dec);
    add(0, T_BNE, 6'd0, 1'b1, e_bne);
    add(0, T_JAL, 6'd0, 1'b1, e_fr);  add(0, T_JAL, 6'd0, 1'b0, e_dec);
    add(0, T_JAL, 6'd0, 1'b0, e_jal);
    add(0, T_RT, F_JR, 1'b1, e_fr);   add(0, T_RT, F_JR, 1'b0, e_dec);
    add(0, T_RT, F_JR, 1'b0, e_ex_a); add(0, T_RT, F_JR, 1'b0, e_jr);
    add(0, T_RT, F_SRA, 1'b1, e_fr);  add(0, T_RT, F_SRA, 1'b1, e_dec);
    add(0, T_RT, F_SRA, 1'b1, e_sra); add(0, T_RT, F_SRA, 1'b1, e_rwb);
    add(0, T_SLTI, 6'd0, 1'b1, e_fr); add(0, T_SLTI, 6'd0, 1'b1, e_dec);
    add(0, T_SLTI, 6'd0, 1'b1, e_slti); add(0, T_SLTI, 6'd0, 1'b1, e_iwb);
    add(0, T_SW, 6'd0, 1'b1, e_fr);   add(0, T_SW, 6'd0, 1'b1, e_dec);
    add(0, T_SW, 6'd0, 1'b1, e_maddr); add(0, T_SW, 6'd0, 1'b0, e_mwr_w);
    add(0, T_SW, 6'd0, 1'b1, e_mwr_w);
    add(0, T_RT, F_SLT, 1'b1, e_fr);  add(0, T_RT, F_SLT, 1'b1, e_dec);
    add(0, T_RT, F_SLT, 1'b1, e_slt); add(0, T_RT, F_SLT, 1'b1, e_rwb);
    add(0, T_BAD, 6'd0, 1'b1, e_fr);  add(0, T_BAD, 6'd0, 1'b1, e_dec_ill);
    add(0, T_BAD, 6'd0, 1'b1, e_halt);
    // No handshake, no halt on illegal
    add(1, T_SB, 6'd0, 1'b0, e_fr);   add(1, T_SB, 6'd0, 1'b0, e_dec);
    add(1, T_SB, 6'd0, 1'b0, e_maddr); add(1, T_SB, 6'd0, 1'b0, e_mwr_b);
    add(1, T_RT, F_BAD, 1'b0, e_fr);  add(1, T_RT, F_BAD, 1'b0, e_dec);
    add(1, T_RT, F_BAD, 1'b0, e_rill);
    add(1, T_BAD, 6'd0, 1'b0, e_fr);  add(1, T_BAD, 6'd0, 1'b0, e_dec_ill);
    add(1, T_LB, 6'd0, 1'b0, e_fr);   add(1, T_LB, 6'd0, 1'b0, e_dec);
    add(1, T_LB, 6'd0, 1'b0, e_maddr); add(1, T_LB, 6'd0, 1'b0, e_mrd_b);
    add(1, T_LB, 6'd0, 1'b0, e_mwb);
    add(1, T_LUI, 6'd0, 1'b0, e_fr);  add(1, T_LUI, 6'd0, 1'b0, e_dec);
    add(1, T_LUI, 6'd0, 1'b0, e_lui); add(1, T_LUI, 6'd0, 1'b0, e_iwb);
    add(1, T_J, 6'd0, 1'b0, e_fr);    add(1, T_J, 6'd0, 1'b0, e_dec);
    add(1, T_J, 6'd0, 1'b0, e_jmp);
    add(1, T_LBU, 6'd0, 1'b0, e_fr);  add(1, T_LBU, 6'd0, 1'b0, e_dec);
    add(1, T_LBU, 6'd0, 1'b0, e_maddr); add(1, T_LBU, 6'd0, 1'b0, e_mrd_u);
    add(1, T_LBU, 6'd0, 1'b0, e_mwb);  add(1, T_LBU, 6'd0, 1'b0, e_fr);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_h   = 1'b0;
    rst_n2  = 1'b0;
    bus_h.op = 6'd0; bus_h.funct = 6'd0; bus_h.mem_ready = 1'b0;
    bus_n.op = 6'd0; bus_n.funct = 6'd0; bus_n.mem_ready = 1'b0;
    init_exp();
    build_table();

    step(0, T_LW, 6'd0, 1'b1, e_zero, "reset_h");
    step(1, T_SW, 6'd0, 1'b1, e_zero, "reset_n");
    rst_h = 1'b1;
    run_vectors(0);

    for (int i = 0; i < 20; i++)
      step(0, T_LW, 6'd0, 1'(i % 2), e_halt, "halt_hold");

    // Reset leaves HALT, then is re-asserted between edges during a store
    @(negedge clk);
    rst_h = 1'b0;
    #1 chk(0, e_zero, "halt_reset");
    step(0, T_SW, 6'd0, 1'b1, e_zero, "reset_hold");
    rst_h = 1'b1;
    step(0, T_SW, 6'd0, 1'b1, e_fr, "first_fetch");
    step(0, T_SW, 6'd0, 1'b1, e_dec, "sw_decode");
    step(0, T_SW, 6'd0, 1'b1, e_maddr, "sw_addr");
    step(0, T_SW, 6'd0, 1'b0, e_mwr_w, "sw_req");
    @(posedge clk);
    #1 chk(0, e_mwr_w, "sw_wait");
    #1 rst_h = 1'b0;
    #1 chk(0, e_zero, "rst_mid_write");
    step(0, T_SW, 6'd0, 1'b0, e_zero, "rst_state");
    rst_h = 1'b1;
    step(0, T_SW, 6'd0, 1'b0, e_fw, "fetch_after_rst");

    chk(1, e_zero, "n_held_reset");
    @(negedge clk);
    rst_n2 = 1'b1;
    run_vectors(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller_v2.md
# mips_mc_controller_v2

Parametrised successor to the multicycle MIPS control FSM. It sits between the instruction register (op/funct) and the datapath/memory, and generates every mux select, write enable and ALU opcode per state. Over the first generation it adds:
- a memory ready handshake that inserts wait states;
- new instructions SW, BNE, JAL, JR, AND, SLT and SLTI;
- an illegal-instruction policy;
- an asynchronous active-low reset.

## Interface
Parameters:
- ALUOP_W, 5: ALUOP width. Must be ≥ 5.
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
- HALT_ON_ILLEGAL, 1: 1 = an undefined op/funct enters HALT; 0 = pulse illegal and return to FETCH.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  reset; one clock, asynchronous assert, active-low
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current access this cycle
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- MemMode  out  2  access size: 00 word, 01 signed byte, 10 unsigned byte
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  conditional PC load on branch
- BranchNe  out  1  branch polarity: 0 = taken on Zero, 1 = taken on !Zero
- PCSource  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target, 11 register A
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- IRWrite  out  1  instruction register load
- RegWrite  out  1  register file write
- RegDst  out  2  destination register: 00 rt, 01 rd, 10 r31
- MemToReg  out  2  write-back data: 00 ALUOut, 01 MDR, 10 PC
- ALUSrcA  out  2  ALU A input: 00 PC, 01 A, 10 shamt
- ALUSrcB  out  2  ALU B input: 00 B, 01 const 4, 10 imm, 11 imm<<2
- ALUOP  out  ALUOP_W  ALU operation, zero-extended codes below
- halted  out  1  high while state is HALT
- illegal  out  1  one-cycle pulse in DECODE or RTYPE_EX on an undefined encoding

## Operation
- Every output defaults to 0 and is a function of the state, plus op/funct/mem_ready where noted. Outputs are combinational.
- ALUOP codes:
  - add 00000, or 00001, and 00010, sll 00100, srl 00101, sra 00110
  - lui 00111, ori 01000, sub 01001, slt 01010
- States and their outputs/transitions:
  - RESET: all outputs 0. Next state FETCH.
  - FETCH: MemRead=1, ALUSrcB=01. IRWrite and PCWrite are asserted only when mem_ready=1. Stay in FETCH while mem_ready=0, otherwise go to DECODE.
  - DECODE: ALUSrcB=11. Next state by op:
    - LW/LB/LBU/SW/SB → MEM_ADDR
    - RTYPE → RTYPE_EX
    - ORI/LUI/ADDI/ADDIU/SLTI → IMM_EX
    - BEQ/BNE → BRANCH
    - J → JUMP
    - JAL → JAL
    - anything else → illegal policy
  - MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOP add. Next MEM_READ for loads, MEM_WRITE for stores.
  - MEM_READ: MemRead=1, IorD=1, MemMode from op (LW 00, LB 01, LBU 10). Stay while mem_ready=0, then go to MEM_WB.
  - MEM_WB: RegWrite=1, MemToReg=01, RegDst=00. Next FETCH.
  - MEM_WRITE: MemWrite=1, IorD=1, MemMode 00 for SW and 01 for SB. Held until mem_ready, then FETCH.
  - RTYPE_EX: ALUSrcB=00. ALUSrcA=10 for SLL/SRL/SRA, 01 otherwise. ALUOP from funct:
    - ADD/ADDU → add; SUB/SUBU → sub
    - OR → or; AND → and; SLT → slt
    - shifts → sll/srl/sra
    - JR (001000) → next state JR
    - undefined funct → illegal policy
    - all others → next state RTYPE_WB
  - RTYPE_WB: RegWrite=1, RegDst=01, MemToReg=00. Next FETCH.
  - IMM_EX: ALUSrcA=01, ALUSrcB=10. ALUOP: ORI ori, LUI lui, ADDI/ADDIU add, SLTI slt. Next IMM_WB.
  - IMM_WB: RegWrite=1, RegDst=00. Next FETCH.
  - BRANCH: ALUSrcA=01, ALUOP sub, PCSource=01, PCWriteCond=1, BranchNe=(op==BNE). Next FETCH.
  - JUMP: PCWrite=1, PCSource=10. Next FETCH.
  - JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemToReg=10. The register file samples the PC (already PC+4) on the same edge the PC loads. Next FETCH.
  - JR: PCWrite=1, PCSource=11. Next FETCH.
  - HALT: halted=1, all else 0. Stays in HALT until reset.
- Illegal policy: illegal=1 in the detecting cycle. Next state is HALT if HALT_ON_ILLEGAL=1, otherwise FETCH.

## Timing
- Reset: reset_n=0 forces state RESET immediately, regardless of clk. All outputs read 0 within that same cycle, including mid-access; a pending MemWrite is dropped. The first FETCH is one clk edge after reset_n rises.
- Base latency in cycles, with no wait states:
  - loads 5
  - stores 4
  - R-type 4, immediate 4
  - branch 3, J 3, JAL 3, JR 4
- Each cycle mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Request outputs stay stable and unchanged throughout the wait.
- With MEM_HANDSHAKE=0, latency equals the base latency.
- mem_ready outside the memory states has no effect.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode and funct constants
  - ALUOP codes
  - the state enum (6-bit encoding)
  - PCSource/RegDst/MemToReg/ALUSrc select encodings
- Sub-module mips_ctrl_decode: purely combinational mapping of op/funct to instruction class, ALUOP, MemMode and legal flag. The FSM (registered state, output logic) is in the top module.

## Test plan
- Reset then LW, with mem_ready low 2 cycles in FETCH and 3 cycles in MEM_READ → 10 cycles FETCH-to-FETCH; IRWrite is high only in the ready cycle; MemToReg=01 and RegWrite=1 in the final cycle.
- SB with MEM_HANDSHAKE=0 and mem_ready held 0 → 4 cycles; MemWrite=1 and MemMode=01 for exactly one cycle.
- BNE (op 000101) → the BRANCH cycle shows PCWriteCond=1, BranchNe=1, ALUOP=01001, PCSource=01.
- JAL then JR (funct 001000):
  - JAL cycle: RegDst=10, MemToReg=10, RegWrite=1, PCSource=10, all simultaneous.
  - JR: PCSource=11 in its 4th cycle.
- op 111111:
  - HALT_ON_ILLEGAL=1 → illegal pulse, then halted stays high for 20 cycles.
  - HALT_ON_ILLEGAL=0 → illegal pulse, then FETCH on the next cycle.
- Assert reset_n low between clk edges during MEM_WRITE → MemWrite drops to 0 before the next edge; state is RESET, then FETCH.
